mem_access_ctrl: RTL and testbench

- CPU-side initiator for the byte-addressed data RAM's MOV/MOC handshake.
- Accepts one load/store request per transaction from the control unit and drives MOV, ReadWrite, MS_2_0, Address and DataIn to the RAM.
- Waits for MOC, captures read data, then retires MOC with a MOCoff pulse.
- Rejects misaligned or illegal-size requests and times out a RAM that never answers.

---
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// CPU-side MOV/MOC handshake initiator for the byte-addressed data RAM.
// One load/store per transaction, with alignment checking and a response timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        RW,
    input  logic [2:0]  Size,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    output logic        MOCoff,
    input  logic        MOC,
    input  logic [31:0] DataOut
);

    typedef enum logic [1:0] {IDLE, REQ, ACK, FIN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              flag, flag_d;
    logic              mov_d, mocoff_d, rw_d, busy_d, done_d, err_d;
    logic [2:0]        ms_d;
    logic [31:0]       addr_d, din_d, rdata_d;
    logic              bad_req;

    // Illegal size, or halfword/word not naturally aligned.
    always_comb begin
        unique case (Size[1:0])
            2'b01:   bad_req = Addr[0];
            2'b10:   bad_req = (Addr[1:0] != 2'b00);
            2'b11:   bad_req = 1'b1;
            default: bad_req = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state;
        cnt_d    = cnt;
        flag_d   = flag;
        mov_d    = MOV;
        mocoff_d = MOCoff;
        rw_d     = ReadWrite;
        ms_d     = MS_2_0;
        addr_d   = Address;
        din_d    = DataIn;
        rdata_d  = RData;
        busy_d   = Busy;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    rw_d   = RW;
                    ms_d   = Size;
                    addr_d = Addr;
                    din_d  = WData;
                    busy_d = 1'b1;
                    flag_d = bad_req;
                    if (bad_req) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        mov_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (MOC) begin
                    if (ReadWrite) rdata_d = DataOut;
                    mov_d    = 1'b0;
                    mocoff_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ACK;
                end else if (cnt == CNT_LAST) begin
                    mov_d    = 1'b0;
                    mocoff_d = 1'b1;
                    flag_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ACK: begin
                if (!MOC) begin
                    mocoff_d = 1'b0;
                    state_d  = FIN;
                    done_d   = 1'b1;
                    err_d    = flag;
                end else if (cnt == CNT_LAST) begin
                    mocoff_d = 1'b0;
                    flag_d   = 1'b1;
                    state_d  = FIN;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            flag      <= 1'b0;
            MOV       <= 1'b0;
            MOCoff    <= 1'b0;
            ReadWrite <= 1'b0;
            MS_2_0    <= 3'b000;
            Address   <= '0;
            DataIn    <= '0;
            RData     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            flag      <= flag_d;
            MOV       <= mov_d;
            MOCoff    <= mocoff_d;
            ReadWrite <= rw_d;
            MS_2_0    <= ms_d;
            Address   <= addr_d;
            DataIn    <= din_d;
            RData     <= rdata_d;
            Busy      <= busy_d;
            Done      <= done_d;
            Err       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against a little-endian byte RAM model
// that can answer immediately, never answer, or hold MOC high.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        RW;
    logic [2:0]  Size;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Busy, Done, Err, MOV, ReadWrite, MOCoff, MOC;
    logic [2:0]  MS_2_0;
    logic [31:0] Address, DataIn, DataOut;

    mem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .RW(RW), .Size(Size),
        .Addr(Addr), .WData(WData), .RData(RData), .Busy(Busy), .Done(Done),
        .Err(Err), .MOV(MOV), .ReadWrite(ReadWrite), .MS_2_0(MS_2_0),
        .Address(Address), .DataIn(DataIn), .MOCoff(MOCoff), .MOC(MOC),
        .DataOut(DataOut)
    );

    always #5 Clk = ~Clk;

    // RAM model: mode 0 answers at once, 1 never answers, 2 holds MOC while MOCoff is up.
    localparam logic [1:0] M_OK = 2'd0, M_NONE = 2'd1, M_STUCK = 2'd2;
    logic [1:0] mode;
    logic [7:0] mem [256];

    assign MOC = (mode == M_OK)    ? MOV :
                 (mode == M_STUCK) ? (MOV | MOCoff) : 1'b0;

    always_comb begin
        logic [7:0] a;
        logic [7:0] b0, b1, b2, b3;
        a  = Address[7:0];
        b0 = mem[a];
        b1 = mem[a + 8'd1];
        b2 = mem[a + 8'd2];
        b3 = mem[a + 8'd3];
        case (MS_2_0[1:0])
            2'b00:   DataOut = {{24{MS_2_0[2] & b0[7]}}, b0};
            2'b01:   DataOut = {{16{MS_2_0[2] & b1[7]}}, b1, b0};
            default: DataOut = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge Clk) begin
        if (MOV && MOC && !ReadWrite) begin
            mem[Address[7:0]] <= DataIn[7:0];
            if (MS_2_0[1:0] != 2'b00) mem[Address[7:0] + 8'd1] <= DataIn[15:8];
            if (MS_2_0[1:0] == 2'b10) begin
                mem[Address[7:0] + 8'd2] <= DataIn[23:16];
                mem[Address[7:0] + 8'd3] <= DataIn[31:24];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mode;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_mov;
        int          exp_moff;
    } vec_t;

    // Issue one request at a falling edge, then watch until Done (bounded).
    task automatic run_txn(input vec_t v, input int idx);
        int lat, movc, moffc;
        logic got_done, err_seen;
        lat = 0; movc = 0; moffc = 0; got_done = 1'b0; err_seen = 1'b0;
        @(negedge Clk);
        mode = v.mode; RW = v.rw; Size = v.size; Addr = v.addr; WData = v.wdata;
        Start = 1'b1;
        while (!got_done && lat < 60) begin
            @(negedge Clk);
            Start = 1'b0;
            lat++;
            if (MOV) movc++;
            if (MOCoff) moffc++;
            if (Done) begin
                got_done = 1'b1;
                err_seen = Err;
            end
        end
        check($sformatf("v%0d done_seen", idx), 32'(got_done), 32'd1);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d err", idx), 32'(err_seen), 32'(v.exp_err));
        check($sformatf("v%0d mov_cycles", idx), 32'(movc), 32'(v.exp_mov));
        check($sformatf("v%0d mocoff_cycles", idx), 32'(moffc), 32'(v.exp_moff));
        check($sformatf("v%0d rdata", idx), RData, v.exp_rdata);
        @(negedge Clk);
        check($sformatf("v%0d busy_after", idx), 32'(Busy), 32'd0);
        check($sformatf("v%0d done_after", idx), 32'(Done), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int dones;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h80;
        mode = M_OK; Start = 1'b0; RW = 1'b0; Size = 3'b000; Addr = '0; WData = '0;
        Reset_n = 1'b0;

        //        rw    size    addr   wdata         mode    err   rdata         lat mov moff
        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'hDEADBEEF, M_OK,    1'b0, 32'h00000000, 3,  1,  1};
        vecs[1]  = '{1'b1, 3'b010, 32'h10, 32'h0,        M_OK,    1'b0, 32'hDEADBEEF, 3,  1,  1};
        vecs[2]  = '{1'b1, 3'b100, 32'h21, 32'h0,        M_OK,    1'b0, 32'hFFFFFF80, 3,  1,  1};
        vecs[3]  = '{1'b1, 3'b000, 32'h21, 32'h0,        M_OK,    1'b0, 32'h00000080, 3,  1,  1};
        vecs[4]  = '{1'b1, 3'b101, 32'h10, 32'h0,        M_OK,    1'b0, 32'hFFFFBEEF, 3,  1,  1};
        vecs[5]  = '{1'b1, 3'b001, 32'h03, 32'h0,        M_OK,    1'b1, 32'hFFFFBEEF, 1,  0,  0};
        vecs[6]  = '{1'b1, 3'b010, 32'h06, 32'h0,        M_OK,    1'b1, 32'hFFFFBEEF, 1,  0,  0};
        vecs[7]  = '{1'b1, 3'b011, 32'h00, 32'h0,        M_OK,    1'b1, 32'hFFFFBEEF, 1,  0,  0};
        vecs[8]  = '{1'b0, 3'b000, 32'h12, 32'h00000055, M_OK,    1'b0, 32'hFFFFBEEF, 3,  1,  1};
        vecs[9]  = '{1'b1, 3'b010, 32'h10, 32'h0,        M_OK,    1'b0, 32'hDE55BEEF, 3,  1,  1};
        vecs[10] = '{1'b1, 3'b010, 32'h10, 32'h0,        M_NONE,  1'b1, 32'hDE55BEEF, 18, 16, 1};
        vecs[11] = '{1'b1, 3'b000, 32'h21, 32'h0,        M_OK,    1'b0, 32'h00000080, 3,  1,  1};
        vecs[12] = '{1'b0, 3'b010, 32'h30, 32'h11223344, M_STUCK, 1'b1, 32'h00000080, 18, 1,  16};
        vecs[13] = '{1'b1, 3'b010, 32'h30, 32'h0,        M_OK,    1'b0, 32'h11223344, 3,  1,  1};

        #12;
        check("reset MOV", 32'(MOV), 32'd0);
        check("reset MOCoff", 32'(MOCoff), 32'd0);
        check("reset Busy", 32'(Busy), 32'd0);
        check("reset Done", 32'(Done), 32'd0);
        check("reset Err", 32'(Err), 32'd0);
        check("reset RData", RData, 32'd0);
        check("reset Address", Address, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

        // Reset asserted while waiting in REQ.
        @(negedge Clk);
        mode = M_NONE; RW = 1'b1; Size = 3'b010; Addr = 32'h10; Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("req MOV before reset", 32'(MOV), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("req rst MOV", 32'(MOV), 32'd0);
        check("req rst MOCoff", 32'(MOCoff), 32'd0);
        check("req rst Busy", 32'(Busy), 32'd0);
        check("req rst Done", 32'(Done), 32'd0);
        check("req rst RData", RData, 32'd0);
        @(negedge Clk); Reset_n = 1'b1;

        // Reset asserted while MOC is held in ACK.
        @(negedge Clk);
        mode = M_STUCK; RW = 1'b0; Size = 3'b010; Addr = 32'h40; WData = 32'hA5A5A5A5; Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("ack MOCoff before reset", 32'(MOCoff), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        check("ack rst MOV", 32'(MOV), 32'd0);
        check("ack rst MOCoff", 32'(MOCoff), 32'd0);
        check("ack rst Busy", 32'(Busy), 32'd0);
        check("ack rst Done", 32'(Done), 32'd0);
        @(negedge Clk); Reset_n = 1'b1; mode = M_OK;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("no done after reset", 32'(dones), 32'd0);

        // Second Start while Busy must be ignored.
        @(negedge Clk);
        RW = 1'b1; Size = 3'b000; Addr = 32'h21; Start = 1'b1;
        dones = 0;
        @(negedge Clk);
        if (Done) dones++;
        Addr = 32'h10; Size = 3'b010;
        @(negedge Clk);
        if (Done) dones++;
        Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("busy start done count", 32'(dones), 32'd1);
        check("busy start rdata", RData, 32'h00000080);
        check("busy start address held", Address, 32'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
